// File: rtl/tank_pkg.sv
// Shared types and helpers for the bullet pool: coordinates, headings, slot states.
package tank_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned TRIG_W   = 8;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [COORD_W-1:0]       coord_t;
  typedef logic signed [TRIG_W-1:0] trig_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FLIGHT = 1'b1
  } slot_state_e;

  // Arithmetic-shift a heading component and sign-extend it to a coordinate step.
  function automatic coord_t trig_to_vel(input trig_t t, input int unsigned sh);
    trig_t v_s;
    v_s = t >>> sh;
    return {{(COORD_W-TRIG_W){v_s[TRIG_W-1]}}, v_s};
  endfunction

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: state, position, velocity, life; bounce and expiry on frame_tick.
// BULLET_POOL_SELF_HIT_EN: o_self_ok flags the slot as old enough to hit its own tank.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int unsigned LIFETIME = 300
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_tick,
  input  logic   i_clear,
  input  logic   i_alloc,
  input  logic   i_kill,
  input  coord_t i_x0,
  input  coord_t i_y0,
  input  coord_t i_vx0,
  input  coord_t i_vy0,
  input  logic   i_wall_x,
  input  logic   i_wall_y,
  output coord_t o_x,
  output coord_t o_y,
  output logic   o_act,
  output logic   o_self_ok
);

  localparam int unsigned LIFE_W = $clog2(LIFETIME + 1);

  slot_state_e       r_state;
  coord_t            r_x, r_y, r_vx, r_vy;
  logic [LIFE_W-1:0] r_life;

  coord_t w_vx, w_vy, w_nx, w_ny;
  logic   w_expire;

  // Reflect first, then step; wrap past zero lands far off-screen.
  always_comb begin
    w_vx     = i_wall_x ? (COORD_W'(0) - r_vx) : r_vx;
    w_vy     = i_wall_y ? (COORD_W'(0) - r_vy) : r_vy;
    w_nx     = r_x + w_vx;
    w_ny     = r_y + w_vy;
    w_expire = (r_life == LIFE_W'(1)) || (w_nx >= COORD_W'(SCREEN_W))
            || (w_ny >= COORD_W'(SCREEN_H));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_life  <= '0;
    end else if (i_clear) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_alloc) begin
            r_state <= FLIGHT;
            r_x     <= i_x0;
            r_y     <= i_y0;
            r_vx    <= i_vx0;
            r_vy    <= i_vy0;
            r_life  <= LIFE_W'(LIFETIME);
          end
        end
        FLIGHT: begin
          if (i_kill) begin
            r_state <= IDLE;
          end else if (i_tick) begin
            r_vx   <= w_vx;
            r_vy   <= w_vy;
            r_x    <= w_nx;
            r_y    <= w_ny;
            r_life <= r_life - LIFE_W'(1);
            if (w_expire) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_x   = r_x;
  assign o_y   = r_y;
  assign o_act = (r_state == FLIGHT);

`ifdef BULLET_POOL_SELF_HIT_EN
  assign o_self_ok = (LIFETIME - 32'(r_life)) >= 32'd8;
`else
  assign o_self_ok = 1'b0;
`endif

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Bullet pool for all players: fire edge detect, cooldowns, slot allocation, hit reporting.
// Optional BULLET_POOL_SELF_HIT_EN lets aged bullets hit their own shooter.
module bullet_pool_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS        = 2,
  parameter int unsigned BULLETS_PER_PLAYER = 3,
  parameter int unsigned LIFETIME           = 300,
  parameter int unsigned COOLDOWN           = 35,
  parameter int unsigned VEL_SHIFT          = 5,
  parameter int unsigned HIT_HALF           = 5
) (
  input  logic                                          CLK,
  input  logic                                          RESET_N,
  input  logic                                          frame_tick,
  input  logic                                          game_reset,
  input  logic [NUM_PLAYERS-1:0]                        fire,
  input  logic [NUM_PLAYERS*COORD_W-1:0]                tank_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]                tank_y,
  input  logic [NUM_PLAYERS*TRIG_W-1:0]                 sin_i,
  input  logic [NUM_PLAYERS*TRIG_W-1:0]                 cos_i,
  input  logic [NUM_PLAYERS*BULLETS_PER_PLAYER-1:0]     wall_x,
  input  logic [NUM_PLAYERS*BULLETS_PER_PLAYER-1:0]     wall_y,
  output logic [NUM_PLAYERS*BULLETS_PER_PLAYER*COORD_W-1:0] bullet_x,
  output logic [NUM_PLAYERS*BULLETS_PER_PLAYER*COORD_W-1:0] bullet_y,
  output logic [NUM_PLAYERS*BULLETS_PER_PLAYER-1:0]     bullet_act,
  output logic [NUM_PLAYERS-1:0]                        tank_hit
);

  localparam int unsigned S    = NUM_PLAYERS * BULLETS_PER_PLAYER;
  localparam int unsigned CD_W = $clog2(COOLDOWN + 1);

  logic [NUM_PLAYERS-1:0] r_fire_d, r_tank_hit, w_fire_ok, w_granted, w_hit_c;
  logic [CD_W-1:0]        r_cool [NUM_PLAYERS];
  logic [S-1:0]           w_alloc, w_kill, w_act, w_self_ok;
  coord_t                 w_tx [NUM_PLAYERS], w_ty [NUM_PLAYERS];
  coord_t                 w_vx0 [NUM_PLAYERS], w_vy0 [NUM_PLAYERS];
  coord_t                 w_bx [S], w_by [S];

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
    assign w_tx[gp]  = tank_x[gp*COORD_W +: COORD_W];
    assign w_ty[gp]  = tank_y[gp*COORD_W +: COORD_W];
    assign w_vx0[gp] = trig_to_vel(trig_t'(cos_i[gp*TRIG_W +: TRIG_W]), VEL_SHIFT);
    assign w_vy0[gp] = trig_to_vel(trig_t'(sin_i[gp*TRIG_W +: TRIG_W]), VEL_SHIFT);
  end

  // Lowest free slot of the player takes an accepted fire edge.
  always_comb begin
    logic v_found;
    w_alloc   = '0;
    w_fire_ok = '0;
    w_granted = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      v_found      = 1'b0;
      w_fire_ok[p] = fire[p] & ~r_fire_d[p] & (r_cool[p] == '0) & ~game_reset;
      for (int unsigned b = 0; b < BULLETS_PER_PLAYER; b++) begin
        if (!v_found && !w_act[p*BULLETS_PER_PLAYER + b]) begin
          w_alloc[p*BULLETS_PER_PLAYER + b] = w_fire_ok[p];
          v_found = 1'b1;
        end
      end
      w_granted[p] = w_fire_ok[p] & v_found;
    end
  end

  // Box overlap of every flying slot against every eligible tank.
  always_comb begin
    w_kill  = '0;
    w_hit_c = '0;
    for (int unsigned s = 0; s < S; s++) begin
      for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
        if (w_act[s] && ((q != s / BULLETS_PER_PLAYER) || w_self_ok[s])
            && (abs_diff(w_bx[s], w_tx[q]) <= COORD_W'(HIT_HALF))
            && (abs_diff(w_by[s], w_ty[q]) <= COORD_W'(HIT_HALF))) begin
          w_kill[s]  = 1'b1;
          w_hit_c[q] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_fire_d   <= '0;
      r_tank_hit <= '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) r_cool[p] <= '0;
    end else begin
      r_fire_d   <= fire;
      r_tank_hit <= game_reset ? '0 : w_hit_c;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        if (game_reset)                         r_cool[p] <= '0;
        else if (w_granted[p])                  r_cool[p] <= CD_W'(COOLDOWN);
        else if (frame_tick && r_cool[p] != '0) r_cool[p] <= r_cool[p] - CD_W'(1);
      end
    end
  end

  for (genvar gs = 0; gs < S; gs++) begin : g_slot
    localparam int unsigned P = gs / BULLETS_PER_PLAYER;
    bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .i_tick   (frame_tick),
      .i_clear  (game_reset),
      .i_alloc  (w_alloc[gs]),
      .i_kill   (w_kill[gs]),
      .i_x0     (w_tx[P]),
      .i_y0     (w_ty[P]),
      .i_vx0    (w_vx0[P]),
      .i_vy0    (w_vy0[P]),
      .i_wall_x (wall_x[gs]),
      .i_wall_y (wall_y[gs]),
      .o_x      (w_bx[gs]),
      .o_y      (w_by[gs]),
      .o_act    (w_act[gs]),
      .o_self_ok(w_self_ok[gs])
    );
    assign bullet_x[gs*COORD_W +: COORD_W] = w_bx[gs];
    assign bullet_y[gs*COORD_W +: COORD_W] = w_by[gs];
  end

  assign bullet_act = w_act;
  assign tank_hit   = r_tank_hit;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Bench for bullet_pool_ctrl: directed scenarios, per-cycle reference model plus literal pins.
module tb_bullet_pool_ctrl;

  localparam int NP = 2, BPP = 3, S = 6, LT = 300, CD = 35, VS = 5, HH = 5, CW = 10;

  logic CLK = 1'b0, RESET_N = 1'b0, frame_tick = 1'b0, game_reset = 1'b0;
  logic [NP-1:0]    fire = '0;
  logic [NP*CW-1:0] tank_x = '0, tank_y = '0;
  logic [NP*8-1:0]  sin_i = '0, cos_i = '0;
  logic [S-1:0]     wall_x = '0, wall_y = '0;
  logic [S*CW-1:0]  bullet_x, bullet_y;
  logic [S-1:0]     bullet_act;
  logic [NP-1:0]    tank_hit;

  int n_checks = 0, n_errors = 0;
  bit chk_en = 1'b0;

  bullet_pool_ctrl #(.NUM_PLAYERS(NP), .BULLETS_PER_PLAYER(BPP), .LIFETIME(LT),
                     .COOLDOWN(CD), .VEL_SHIFT(VS), .HIT_HALF(HH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .frame_tick(frame_tick), .game_reset(game_reset),
    .fire(fire), .tank_x(tank_x), .tank_y(tank_y), .sin_i(sin_i), .cos_i(cos_i),
    .wall_x(wall_x), .wall_y(wall_y), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_act(bullet_act), .tank_hit(tank_hit));

  always #10 CLK = ~CLK;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int bx(input int s); return int'(bullet_x[s*CW +: CW]); endfunction
  function automatic int by(input int s); return int'(bullet_y[s*CW +: CW]); endfunction
  function automatic int txi(input int q); return int'(tank_x[q*CW +: CW]); endfunction
  function automatic int tyi(input int q); return int'(tank_y[q*CW +: CW]); endfunction
  function automatic int iabs(input int v); return (v < 0) ? -v : v; endfunction

  // Reference model: game state as plain integers.
  bit m_act [S];
  int m_x [S], m_y [S], m_vx [S], m_vy [S], m_life [S];
  int m_cool [NP];
  bit [NP-1:0] m_prev, m_hit;

  always @(posedge CLK or negedge RESET_N) begin : model
    bit kill [S];
    bit [NP-1:0] hitq;
    int aidx [NP];
    bit allowed;
    if (!RESET_N) begin
      for (int s = 0; s < S; s++) begin
        m_act[s] = 0; m_x[s] = 0; m_y[s] = 0; m_vx[s] = 0; m_vy[s] = 0; m_life[s] = 0;
      end
      for (int p = 0; p < NP; p++) m_cool[p] = 0;
      m_prev = '0; m_hit = '0;
    end else begin
      hitq = '0;
      for (int s = 0; s < S; s++) begin
        kill[s] = 0;
        if (m_act[s]) begin
          for (int q = 0; q < NP; q++) begin
            allowed = (s / BPP) != q;
`ifdef BULLET_POOL_SELF_HIT_EN
            if ((LT - m_life[s]) >= 8) allowed = 1;
`endif
            if (allowed && iabs(m_x[s] - txi(q)) <= HH && iabs(m_y[s] - tyi(q)) <= HH) begin
              kill[s] = 1; hitq[q] = 1'b1;
            end
          end
        end
      end
      if (game_reset) begin
        for (int s = 0; s < S; s++) m_act[s] = 0;
        for (int p = 0; p < NP; p++) m_cool[p] = 0;
        m_hit = '0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          aidx[p] = -1;
          if (fire[p] && !m_prev[p] && m_cool[p] == 0)
            for (int b = 0; b < BPP; b++)
              if (aidx[p] < 0 && !m_act[p*BPP + b]) aidx[p] = p*BPP + b;
          if (aidx[p] >= 0) m_cool[p] = CD;
          else if (frame_tick && m_cool[p] > 0) m_cool[p]--;
        end
        for (int s = 0; s < S; s++) begin
          if (m_act[s]) begin
            if (kill[s]) m_act[s] = 0;
            else if (frame_tick) begin
              if (wall_x[s]) m_vx[s] = -m_vx[s];
              if (wall_y[s]) m_vy[s] = -m_vy[s];
              m_x[s] = ((m_x[s] + m_vx[s]) % 1024 + 1024) % 1024;
              m_y[s] = ((m_y[s] + m_vy[s]) % 1024 + 1024) % 1024;
              m_life[s]--;
              if (m_life[s] == 0 || m_x[s] >= 640 || m_y[s] >= 480) m_act[s] = 0;
            end
          end
        end
        for (int p = 0; p < NP; p++) begin
          if (aidx[p] >= 0) begin
            m_act[aidx[p]]  = 1;
            m_x[aidx[p]]    = txi(p);
            m_y[aidx[p]]    = tyi(p);
            m_vx[aidx[p]]   = int'($signed(cos_i[p*8 +: 8])) >>> VS;
            m_vy[aidx[p]]   = int'($signed(sin_i[p*8 +: 8])) >>> VS;
            m_life[aidx[p]] = LT;
          end
        end
        m_hit = hitq;
      end
      m_prev = fire;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    bit [S-1:0] eact;
    if (chk_en) begin
      for (int s = 0; s < S; s++) eact[s] = m_act[s];
      chk("model_act", int'(bullet_act), int'(eact));
      chk("model_hit", int'(tank_hit), int'(m_hit));
      for (int s = 0; s < S; s++) begin
        if (m_act[s]) begin
          chk($sformatf("model_x%0d", s), bx(s), m_x[s]);
          chk($sformatf("model_y%0d", s), by(s), m_y[s]);
        end
      end
    end
  end

  task automatic step(input bit t);
    frame_tick = t; @(negedge CLK); frame_tick = 1'b0;
  endtask
  task automatic ticks(input int n); repeat (n) step(1'b1); endtask
  task automatic press(input int p);
    fire[p] = 1'b1; step(1'b0); fire[p] = 1'b0; step(1'b0);
  endtask
  task automatic greset();
    game_reset = 1'b1; step(1'b0); game_reset = 1'b0; step(1'b0);
  endtask
  task automatic set_tank(input int p, input int x, input int y);
    tank_x[p*CW +: CW] = CW'(x); tank_y[p*CW +: CW] = CW'(y);
  endtask
  task automatic set_head(input int p, input int s, input int c);
    sin_i[p*8 +: 8] = 8'(s); cos_i[p*8 +: 8] = 8'(c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_tank(0, 100, 100); set_head(0, 0, 64);
    set_tank(1, 500, 400); set_head(1, 0, 0);
    repeat (3) @(negedge CLK);
    chk("reset_act", int'(bullet_act), 0);
    chk("reset_x", int'(bullet_x), 0);
    chk("reset_hit", int'(tank_hit), 0);
    chk_en = 1'b1;
    RESET_N = 1'b1;
    step(1'b0);

    // Fire and straight flight
    press(0);
    chk("fire_act", int'(bullet_act), 1);
    chk("fire_x", bx(0), 100);
    chk("fire_y", by(0), 100);
    ticks(3);
    chk("fly_x", bx(0), 106);
    greset();
    chk("greset_act", int'(bullet_act), 0);

    // Cooldown and pool exhaustion
    press(0); ticks(10); press(0);
    chk("cd_drop", int'(bullet_act), 1);
    ticks(25); press(0);
    chk("cd_ok", int'(bullet_act), 3);
    ticks(35); press(0);
    chk("slot2", int'(bullet_act), 7);
    ticks(35); press(0);
    chk("pool_full", int'(bullet_act), 7);
    chk("pool_x0", bx(0), 310);
    greset();

    // Bounce on both axes
    set_tank(0, 200, 100); set_head(0, 64, 64);
    press(0);
    wall_x[0] = 1'b1; step(1'b1); wall_x[0] = 1'b0;
    chk("bounce_x", bx(0), 198);
    chk("bounce_y0", by(0), 102);
    wall_y[0] = 1'b1; step(1'b1); wall_y[0] = 1'b0;
    step(1'b1);
    chk("bounce_x2", bx(0), 194);
    chk("bounce_y2", by(0), 98);
    greset();
    set_tank(0, 100, 100); set_head(0, 0, 64);

    // Hit by the other player
    set_tank(1, 300, 300); press(1); set_tank(1, 500, 400);
    chk("hit_pre_act", int'(bullet_act), 8);
    set_tank(0, 303, 298); step(1'b0);
    chk("hit_pulse", int'(tank_hit), 1);
    chk("hit_freed", int'(bullet_act), 0);
    step(1'b0);
    chk("hit_once", int'(tank_hit), 0);
    greset();

    // Own bullet over own tank
    set_tank(0, 300, 300); set_head(0, 0, 0);
    press(0); ticks(3);
    chk("self_act", int'(bullet_act), 1);
    chk("self_nohit", int'(tank_hit), 0);
    ticks(10);
    greset();
    set_tank(0, 100, 100); set_head(0, 0, 64);

    // Two slots hitting one tank together; box edge
    set_tank(1, 400, 200); press(1); set_tank(1, 500, 400);
    ticks(35);
    set_tank(1, 400, 200); press(1); set_tank(1, 500, 400);
    chk("multi_act", int'(bullet_act), 24);
    set_tank(0, 406, 200); step(1'b0); step(1'b0);
    chk("edge_out", int'(bullet_act), 24);
    set_tank(0, 405, 195); step(1'b0);
    chk("multi_hit", int'(tank_hit), 1);
    chk("multi_freed", int'(bullet_act), 0);
    step(1'b0);
    chk("multi_once", int'(tank_hit), 0);
    set_tank(0, 100, 100);
    greset();

    // Lifetime expiry
    set_tank(1, 400, 200); press(1); set_tank(1, 500, 400);
    ticks(LT - 1);
    chk("life_last", int'(bullet_act), 8);
    ticks(1);
    chk("life_expired", int'(bullet_act), 0);
    greset();

    // Off-screen right and wrap left
    set_tank(0, 637, 100); press(0); step(1'b1);
    chk("edge_x", bx(0), 639);
    step(1'b1);
    chk("offscreen", int'(bullet_act), 0);
    greset();
    set_tank(0, 1, 100); set_head(0, 0, -64);
    press(0); step(1'b1);
    chk("wrap_left", int'(bullet_act), 0);
    greset();
    set_tank(0, 100, 100); set_head(0, 0, 64);

    // Fire in the same cycle as frame_tick
    fire[0] = 1'b1; step(1'b1); fire[0] = 1'b0;
    chk("fire_tick_act", int'(bullet_act), 1);
    chk("fire_tick_x", bx(0), 100);
    step(1'b0);
    greset();

    // game_reset beats hit and fire
    set_tank(1, 400, 200); press(1); set_tank(1, 500, 400);
    set_tank(0, 400, 200); fire[0] = 1'b1; game_reset = 1'b1;
    step(1'b0);
    game_reset = 1'b0; fire[0] = 1'b0;
    chk("gr_nohit", int'(tank_hit), 0);
    chk("gr_act", int'(bullet_act), 0);
    step(1'b0);
    chk("gr_nohit2", int'(tank_hit), 0);
    set_tank(0, 100, 100);
    greset();

    // Asynchronous reset mid-flight
    press(0); ticks(2);
    #3 RESET_N = 1'b0;
    #1;
    chk("areset_act", int'(bullet_act), 0);
    chk("areset_x", bx(0), 0);
    chk("areset_hit", int'(tank_hit), 0);
    @(negedge CLK); RESET_N = 1'b1;
    step(1'b0); step(1'b0); step(1'b0);
    chk("post_reset_hit", int'(tank_hit), 0);
    chk("post_reset_act", int'(bullet_act), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
